vel_pwm_gen: RTL and testbench

VEL_PWM_GEN -- requirements
Module: vel_pwm_gen

---
 rtl/vel_pwm_gen_pkg.sv | 53 +++++
 rtl/vel_pwm_gen_deadtime_gen.sv | 79 +++++++
 rtl/vel_pwm_gen.sv | 214 +++++++++++++++++++++
 tb/tb_vel_pwm_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vel_pwm_gen_pkg.sv
// -----------------------------------------------------------------------------
// vel_pwm_gen_pkg
// Shared motor-drive definitions for the velocity PWM generator.
// Contents:
//   pwm_state_e     - bridge FSM states (IDLE / RUN / COAST)
//   PWM_PERIOD      - PWM counter ticks per period (counter runs 0..254)
//   SOFTSTART_STEP  - largest duty change allowed per wrap when soft start is built in
//   CNT_MAX         - last PWM counter value before the wrap
//   sat_abs()       - |signed 9-bit command| saturated to 8 bits
//   ramp_toward()   - move a duty value toward a target by at most SOFTSTART_STEP
// -----------------------------------------------------------------------------
package vel_pwm_gen_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      COAST = 2'd2
   } pwm_state_e;

   localparam int unsigned PWM_PERIOD     = 255;
   localparam int unsigned SOFTSTART_STEP = 16;
   localparam logic [7:0]  CNT_MAX        = 8'(PWM_PERIOD - 1);

   // Magnitude of a two's-complement command; -256 is the only value that
   // does not fit in 8 bits and clamps to 255.
   function automatic logic [7:0] sat_abs(input logic signed [8:0] v);
      logic [8:0] mag;
      mag = v[8] ? (~$unsigned(v) + 9'd1) : $unsigned(v);
      if (mag[8]) begin
         return 8'd255;
      end else begin
         return mag[7:0];
      end
   endfunction

   // One soft-start step from cur toward tgt.
   function automatic logic [7:0] ramp_toward(input logic [7:0] cur, input logic [7:0] tgt);
      if (tgt > cur) begin
         if ((tgt - cur) > 8'(SOFTSTART_STEP)) begin
            return cur + 8'(SOFTSTART_STEP);
         end else begin
            return tgt;
         end
      end else begin
         if ((cur - tgt) > 8'(SOFTSTART_STEP)) begin
            return cur - 8'(SOFTSTART_STEP);
         end else begin
            return tgt;
         end
      end
   endfunction

endpackage

// File: rtl/vel_pwm_gen_deadtime_gen.sv
// -----------------------------------------------------------------------------
// deadtime_gen
// Turns the raw PWM drive p into complementary high/low gate signals with a
// blanking gap at each transition, so the two gates are never on together.
// Parameters:
//   DEAD_TIME    - cycles both gates stay low after p changes
// Ports:
//   CLK          in   clock, rising edge
//   RST_N        in   asynchronous active-low reset
//   i_p          in   raw drive (1 = high side wanted)
//   i_force_off  in   hold both gates low and restart the blanking count
//   o_hi         out  high-side gate (registered)
//   o_lo         out  low-side gate (registered)
// -----------------------------------------------------------------------------
module deadtime_gen #(
   parameter int unsigned DEAD_TIME = 4
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic i_p,
   input  logic i_force_off,
   output logic o_hi,
   output logic o_lo
);

   // Run length saturates one past DEAD_TIME: a gate turns on once p has held
   // its value for more than DEAD_TIME sampled cycles, which yields exactly
   // DEAD_TIME blanked output cycles at each edge.
   localparam int unsigned CW      = $clog2(DEAD_TIME + 2);
   localparam logic [CW-1:0] RUN_SAT = CW'(DEAD_TIME + 1);
   localparam logic [CW-1:0] RUN_MIN = CW'(DEAD_TIME);

   logic          r_p_d;
   logic [CW-1:0] r_run;
   logic          r_hi;
   logic          r_lo;
   logic [CW-1:0] w_run;
   logic          w_settled;

   // Length of the current run of equal p values, including this cycle.
   always_comb begin
      w_run     = CW'(1);
      w_settled = 1'b0;
      if (i_p == r_p_d) begin
         if (r_run == RUN_SAT) begin
            w_run = RUN_SAT;
         end else begin
            w_run = r_run + CW'(1);
         end
      end else begin
         w_run = CW'(1);
      end
      w_settled = (w_run > RUN_MIN);
   end

   // Run-length tracking and registered gate outputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_p_d <= 1'b0;
         r_run <= '0;
         r_hi  <= 1'b0;
         r_lo  <= 1'b0;
      end else if (i_force_off) begin
         r_p_d <= i_p;
         r_run <= '0;
         r_hi  <= 1'b0;
         r_lo  <= 1'b0;
      end else begin
         r_p_d <= i_p;
         r_run <= w_run;
         r_hi  <= i_p & w_settled;
         r_lo  <= ~i_p & w_settled;
      end
   end

   assign o_hi = r_hi;
   assign o_lo = r_lo;

endmodule

// File: rtl/vel_pwm_gen.sv
// -----------------------------------------------------------------------------
// vel_pwm_gen
// Sign/magnitude H-bridge PWM generator driven by a signed velocity command.
// The command is shadowed and applied only at the period wrap; a direction
// reversal inserts one full coast period with both gates off.
// Optional build macro:
//   VEL_PWM_SOFTSTART_EN - limit the duty change per wrap to SOFTSTART_STEP
// Parameters:
//   DEAD_TIME     - blanking cycles at each gate edge
//   PRESCALE      - CLK cycles per PWM counter tick (1..256)
// Ports:
//   CLK           in   clock, rising edge
//   RST_N         in   asynchronous active-low reset
//   enable        in   bridge enable; 0 returns to IDLE (gates low)
//   vel_cmd       in   signed 9-bit velocity command
//   vel_valid     in   one-cycle strobe qualifying vel_cmd
//   pwm_hi        out  high-side gate
//   pwm_lo        out  low-side gate
//   dir           out  applied direction (1 = reverse)
//   duty          out  applied duty magnitude
//   period_start  out  one-cycle pulse when the PWM counter wraps to 0
// -----------------------------------------------------------------------------
module vel_pwm_gen
   import vel_pwm_gen_pkg::*;
#(
   parameter int unsigned DEAD_TIME = 4,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              enable,
   input  logic signed [8:0] vel_cmd,
   input  logic              vel_valid,
   output logic              pwm_hi,
   output logic              pwm_lo,
   output logic              dir,
   output logic [7:0]        duty,
   output logic              period_start
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

   pwm_state_e    r_state;
   pwm_state_e    w_state_nxt;
   logic [PW-1:0] r_presc;
   logic [7:0]    r_cnt;
   logic [7:0]    r_sh_mag;
   logic          r_sh_dir;
   logic [7:0]    r_duty;
   logic          r_dir;
   logic          r_period_start;

   logic          w_active;
   logic          w_tick;
   logic          w_wrap;
   logic [7:0]    w_tgt_mag;
   logic          w_tgt_dir;
   logic          w_reverse;
   logic [7:0]    w_load_duty;
   logic          w_load_dir;
   logic          w_p;
   logic          w_force_off;

   assign w_active = enable && (r_state != IDLE);
   assign w_tick   = (r_presc == PRESC_MAX);
   assign w_wrap   = w_active && w_tick && (r_cnt == CNT_MAX);

   // Target for the wrap: a strobe on the wrap cycle bypasses the shadow.
   // A zero magnitude keeps the current direction and never asks for a coast.
   always_comb begin
      w_tgt_mag   = r_sh_mag;
      w_tgt_dir   = r_sh_dir;
      w_reverse   = 1'b0;
      w_load_dir  = r_dir;
      w_load_duty = 8'd0;
      if (vel_valid) begin
         w_tgt_mag = sat_abs(vel_cmd);
         w_tgt_dir = vel_cmd[8];
      end else begin
         w_tgt_mag = r_sh_mag;
         w_tgt_dir = r_sh_dir;
      end
      w_reverse = (w_tgt_mag != 8'd0) && (w_tgt_dir != r_dir);
      if (w_tgt_mag != 8'd0) begin
         w_load_dir = w_tgt_dir;
      end else begin
         w_load_dir = r_dir;
      end
`ifdef VEL_PWM_SOFTSTART_EN
      w_load_duty = ramp_toward(r_duty, w_tgt_mag);
`else
      w_load_duty = w_tgt_mag;
`endif
   end

   // Next-state logic; dropping enable wins from any state.
   always_comb begin
      w_state_nxt = r_state;
      if (!enable) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = RUN;
            end
            RUN: begin
               if (w_wrap && w_reverse) begin
                  w_state_nxt = COAST;
               end else begin
                  w_state_nxt = RUN;
               end
            end
            COAST: begin
               if (w_wrap) begin
                  w_state_nxt = RUN;
               end else begin
                  w_state_nxt = COAST;
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Prescaler and PWM counter; both held at 0 while idle.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_presc <= '0;
         r_cnt   <= 8'd0;
      end else if (!w_active) begin
         r_presc <= '0;
         r_cnt   <= 8'd0;
      end else if (w_tick) begin
         r_presc <= '0;
         if (r_cnt == CNT_MAX) begin
            r_cnt <= 8'd0;
         end else begin
            r_cnt <= r_cnt + 8'd1;
         end
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   // Command shadow, written on every strobe.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_sh_mag <= 8'd0;
         r_sh_dir <= 1'b0;
      end else if (vel_valid) begin
         r_sh_mag <= sat_abs(vel_cmd);
         r_sh_dir <= vel_cmd[8];
      end else begin
         r_sh_mag <= r_sh_mag;
         r_sh_dir <= r_sh_dir;
      end
   end

   // Applied duty/direction update at the wrap, plus the period_start pulse.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_duty         <= 8'd0;
         r_dir          <= 1'b0;
         r_period_start <= 1'b0;
      end else begin
         r_period_start <= w_wrap;
         if (w_state_nxt == IDLE) begin
            r_duty <= 8'd0;
         end else if (w_wrap) begin
            if ((r_state == RUN) && w_reverse) begin
               r_duty <= 8'd0;
            end else begin
               r_duty <= w_load_duty;
               r_dir  <= w_load_dir;
            end
         end else begin
            r_duty <= r_duty;
         end
      end
   end

   assign w_p = (r_cnt < r_duty);
   // Looking at the next state lets the gates drop on the very cycle COAST or
   // IDLE begins instead of one cycle late.
   assign w_force_off = (w_state_nxt != RUN);

   deadtime_gen #(
      .DEAD_TIME (DEAD_TIME)
   ) u_deadtime (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .i_p         (w_p),
      .i_force_off (w_force_off),
      .o_hi        (pwm_hi),
      .o_lo        (pwm_lo)
   );

   assign dir          = r_dir;
   assign duty         = r_duty;
   assign period_start = r_period_start;

endmodule

// File: tb/tb_vel_pwm_gen.sv
`timescale 1ns/1ps
module tb_vel_pwm_gen;

   logic              CLK = 1'b0;
   logic              RST_N = 1'b0;
   logic              enable = 1'b0;
   logic signed [8:0] vel_cmd = 9'sd0;
   logic              vel_valid = 1'b0;
   logic              pwm_hi;
   logic              pwm_lo;
   logic              dir;
   logic [7:0]        duty;
   logic              period_start;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   vel_pwm_gen #(.DEAD_TIME(4), .PRESCALE(1)) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .enable       (enable),
      .vel_cmd      (vel_cmd),
      .vel_valid    (vel_valid),
      .pwm_hi       (pwm_hi),
      .pwm_lo       (pwm_lo),
      .dir          (dir),
      .duty         (duty),
      .period_start (period_start)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic strobe(input int cmd);
      vel_cmd   = 9'(cmd);
      vel_valid = 1'b1;
      tick();
      vel_valid = 1'b0;
   endtask

   // Tick until period_start is seen or the budget runs out.
   task automatic wait_wrap(input string tag, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!period_start && n < 300);
      check(tag, 32'(period_start), 32'd1);
   endtask

   // Sample one full period (255 cycles) starting at the current sample.
   task automatic measure(output int hi_n, output int lo_n, output int both_n, output int ps_n);
      hi_n = 0; lo_n = 0; both_n = 0; ps_n = 0;
      for (int i = 0; i < 255; i++) begin
         hi_n   += int'(pwm_hi);
         lo_n   += int'(pwm_lo);
         both_n += int'(pwm_hi & pwm_lo);
         ps_n   += int'(period_start);
         tick();
      end
   endtask

   initial begin
      int n;
      int hi_n, lo_n, both_n, ps_n;
      logic [7:0] ramp_exp [5];
`ifdef VEL_PWM_SOFTSTART_EN
      ramp_exp = '{8'd16, 8'd32, 8'd48, 8'd64, 8'd64};
`else
      ramp_exp = '{8'd64, 8'd64, 8'd64, 8'd64, 8'd64};
`endif

      // Reset state
      repeat (3) tick();
      check("rst_hi", 32'(pwm_hi), 32'd0);
      check("rst_lo", 32'(pwm_lo), 32'd0);
      check("rst_dir", 32'(dir), 32'd0);
      check("rst_duty", 32'(duty), 32'd0);
      check("rst_ps", 32'(period_start), 32'd0);
      RST_N = 1'b1;
      repeat (3) tick();
      check("idle_lo", 32'(pwm_lo), 32'd0);
      check("idle_ps", 32'(period_start), 32'd0);

      // Soft start ramp: 0 then +64
      enable    = 1'b1;
      vel_cmd   = 9'sd0;
      vel_valid = 1'b1;
      tick();
      vel_cmd = 9'sd64;
      tick();
      vel_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         wait_wrap("ramp_wrap", n);
         check("ramp_duty", 32'(duty), 32'(ramp_exp[k]));
      end
      check("ramp_dir", 32'(dir), 32'd0);
      enable = 1'b0;
      repeat (2) tick();
      check("dis_duty", 32'(duty), 32'd0);
      check("dis_gates", 32'(pwm_hi | pwm_lo), 32'd0);

`ifndef VEL_PWM_SOFTSTART_EN
      // +100: first wrap 256 cycles after enable, then 96/151 gate split
      enable    = 1'b1;
      vel_cmd   = 9'sd100;
      vel_valid = 1'b1;
      tick();
      vel_valid = 1'b0;
      wait_wrap("wrap100", n);
      check("wrap100_lat", 32'(n + 1), 32'd256);
      check("duty100", 32'(duty), 32'd100);
      check("dir100", 32'(dir), 32'd0);
      measure(hi_n, lo_n, both_n, ps_n);
      check("hi100", 32'(hi_n), 32'd96);
      check("lo100", 32'(lo_n), 32'd151);
      check("both100", 32'(both_n), 32'd0);
      check("dead100", 32'(255 - hi_n - lo_n), 32'd8);
      check("ps100", 32'(period_start), 32'd1);

      // Strobe +200 on the wrap tick takes effect immediately
      repeat (254) tick();
      strobe(200);
      check("byp_ps", 32'(period_start), 32'd1);
      check("byp_duty", 32'(duty), 32'd200);
      measure(hi_n, lo_n, both_n, ps_n);
      check("hi200", 32'(hi_n), 32'd196);
      check("lo200", 32'(lo_n), 32'd51);

      // Reversal +50 -> -50 with one coast period
      repeat (100) tick();
      strobe(50);
      wait_wrap("wrap50", n);
      check("duty50", 32'(duty), 32'd50);
      check("dir50", 32'(dir), 32'd0);
      repeat (10) tick();
      strobe(-50);
      wait_wrap("coast_wrap", n);
      check("coast_duty", 32'(duty), 32'd0);
      check("coast_dir", 32'(dir), 32'd0);
      measure(hi_n, lo_n, both_n, ps_n);
      check("coast_hi", 32'(hi_n), 32'd0);
      check("coast_lo", 32'(lo_n), 32'd0);
      check("coast_ps", 32'(ps_n), 32'd1);
      check("rev_ps", 32'(period_start), 32'd1);
      check("rev_duty", 32'(duty), 32'd50);
      check("rev_dir", 32'(dir), 32'd1);
      measure(hi_n, lo_n, both_n, ps_n);
      check("rev_hi", 32'(hi_n), 32'd46);
      check("rev_lo", 32'(lo_n), 32'd200);
      check("rev_both", 32'(both_n), 32'd0);

      // Saturation -256 -> 255, high side continuously on
      repeat (20) tick();
      strobe(-256);
      wait_wrap("wrap_sat", n);
      check("sat_duty", 32'(duty), 32'd255);
      check("sat_dir", 32'(dir), 32'd1);
      measure(hi_n, lo_n, both_n, ps_n);
      check("sat_hi1", 32'(hi_n), 32'd250);
      check("sat_lo1", 32'(lo_n), 32'd1);
      check("sat_ps1", 32'(period_start), 32'd1);
      measure(hi_n, lo_n, both_n, ps_n);
      check("sat_hi2", 32'(hi_n), 32'd255);
      check("sat_lo2", 32'(lo_n), 32'd0);

      // Zero command: duty 0, direction kept, no coast
      repeat (10) tick();
      strobe(0);
      wait_wrap("wrap_zero", n);
      check("zero_duty", 32'(duty), 32'd0);
      check("zero_dir", 32'(dir), 32'd1);

      // Disable: gates off, no period_start while idle
      enable = 1'b0;
      tick();
      check("off_gates", 32'(pwm_hi | pwm_lo), 32'd0);
      ps_n = 0;
      for (int i = 0; i < 300; i++) begin
         ps_n += int'(period_start);
         tick();
      end
      check("off_ps", 32'(ps_n), 32'd0);

      // Asynchronous reset mid-RUN with duty 100
      enable    = 1'b1;
      vel_cmd   = -9'sd100;
      vel_valid = 1'b1;
      tick();
      vel_valid = 1'b0;
      wait_wrap("wrap_m100", n);
      check("m100_duty", 32'(duty), 32'd100);
      check("m100_dir", 32'(dir), 32'd1);
      repeat (30) tick();
      check("pre_rst_hi", 32'(pwm_hi), 32'd1);
      #2;
      RST_N = 1'b0;
      #1;
      check("arst_hi", 32'(pwm_hi), 32'd0);
      check("arst_lo", 32'(pwm_lo), 32'd0);
      check("arst_dir", 32'(dir), 32'd0);
      check("arst_duty", 32'(duty), 32'd0);
      check("arst_ps", 32'(period_start), 32'd0);
      repeat (2) tick();
      RST_N = 1'b1;
      wait_wrap("post_rst_wrap", n);
      check("post_rst_lat", 32'(n), 32'd256);
      check("post_rst_duty", 32'(duty), 32'd0);
      check("post_rst_dir", 32'(dir), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
